sram_2port_param: RTL and testbench

- Parametrised, synthesizable-style behavioural SRAM for cache tag/data arrays.
- One read/write port (port 0) and one read-only port (port 1), with per-lane write masks.
- Built-in sequential clear engine that zeroes the array after reset.
- Replaces fixed-size single-port models.
- Instantiated inside the I-cache and D-cache tag and data arrays.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_2port_param_if.sv | 32 +++
 rtl/sram_init_ctrl.sv | 51 +++++
 rtl/sram_2port_param.sv | 88 ++++++++
 tb/tb_sram_2port_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, default geometry and lane-count helper for the 2-port SRAM
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_WRITE_SIZE = 24;

    // Returns 0 when the word does not split evenly into lanes; callers treat 0 as fatal.
    function automatic int calc_num_wmasks(input int data_width, input int write_size);
        if (write_size <= 0 || (data_width % write_size) != 0) begin
            return 0;
        end
        return data_width / write_size;
    endfunction

endpackage

// File: rtl/sram_2port_param_if.sv
// rtl/sram_2port_param_if.sv - port 0 (rw) / port 1 (ro) bus bundle with master and slave views
interface sram_2port_param_if
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WRITE_SIZE = DEF_WRITE_SIZE
);
    localparam int NUM_WMASKS = calc_num_wmasks(DATA_WIDTH, WRITE_SIZE);

    logic                  init_done;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;

    modport master (
        input  init_done, dout0, dout1,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output init_done, dout0, dout1,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

endinterface

// File: rtl/sram_init_ctrl.sv
// rtl/sram_init_ctrl.sv - post-reset clear sequencer: walks every address once, then opens the ports
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst,
    output logic                  clear_we_o,
    output logic [ADDR_WIDTH-1:0] clear_addr_o,
    output logic                  init_done_o
);
    sram_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_we_o = 1'b0;
        case (state_q)
            CLEAR: begin
                // The reset cycle itself must leave the array untouched.
                clear_we_o = !rst;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clear_addr_o = cnt_q;
    assign init_done_o  = (state_q == READY);

endmodule

// File: rtl/sram_2port_param.sv
// rtl/sram_2port_param.sv - masked 1rw/1r SRAM with clear-after-reset; SRAM_BYPASS_EN forwards port 0 writes to port 1
module sram_2port_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WRITE_SIZE = DEF_WRITE_SIZE
) (
    input  logic                clk0,
    input  logic                rst,
    sram_2port_param_if.slave   bus
);
    localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NUM_WMASKS = calc_num_wmasks(DATA_WIDTH, WRITE_SIZE);

    if (NUM_WMASKS == 0) begin : g_bad_write_size
        $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
    logic [DATA_WIDTH-1:0] dout1_d;
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  init_done;
    logic                  p0_rd, p0_we, p1_rd;

    sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk0         (clk0),
        .rst          (rst),
        .clear_we_o   (clear_we),
        .clear_addr_o (clear_addr),
        .init_done_o  (init_done)
    );

    assign p0_rd = init_done && !rst && !bus.csb0 && bus.web0;
    assign p0_we = init_done && !rst && !bus.csb0 && !bus.web0;
    assign p1_rd = init_done && !rst && !bus.csb1;

`ifdef SRAM_BYPASS_EN
    always_comb begin
        dout1_d = mem[bus.addr1];
        if (p0_we && (bus.addr0 == bus.addr1)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    dout1_d[i*WRITE_SIZE +: WRITE_SIZE] = bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end
`else
    assign dout1_d = mem[bus.addr1];
`endif

    // The clear engine owns the write path until the array is fully zeroed.
    always_ff @(posedge clk0) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (p0_we) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*WRITE_SIZE +: WRITE_SIZE] <= bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            if (p0_rd) begin
                dout0_q <= mem[bus.addr0];
            end
            if (p1_rd) begin
                dout1_q <= dout1_d;
            end
        end
    end

    assign bus.dout0     = dout0_q;
    assign bus.dout1     = dout1_q;
    assign bus.init_done = init_done;

endmodule

// File: tb/tb_sram_2port_param.sv
// tb/tb_sram_2port_param.sv - directed vector bench for sram_2port_param (default and 64/4/8 geometries)
module tb_sram_2port_param;

    localparam int DW = 48;
    localparam int AW = 6;
    localparam int WS = 24;

`ifdef SRAM_BYPASS_EN
    localparam logic [47:0] COLL7 = 48'h111111_000000;
    localparam logic [47:0] COLL9 = 48'hCAFE00_000000;
`else
    localparam logic [47:0] COLL7 = 48'h0;
    localparam logic [47:0] COLL9 = 48'hCAFE00_00BEEF;
`endif

    logic clk0 = 1'b0;
    logic rst;
    logic rst_p;

    always #5 clk0 = ~clk0;

    sram_2port_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) bus ();
    sram_2port_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .WRITE_SIZE(8)) p_bus ();

    sram_2port_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) dut (
        .clk0 (clk0),
        .rst  (rst),
        .bus  (bus)
    );

    sram_2port_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .WRITE_SIZE(8)) p_dut (
        .clk0 (clk0),
        .rst  (rst_p),
        .bus  (p_bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        csb0;
        logic        web0;
        logic [1:0]  wmask0;
        logic [5:0]  addr0;
        logic [47:0] din0;
        logic        csb1;
        logic [5:0]  addr1;
        logic [47:0] exp0;
        logic [47:0] exp1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic csb0, input logic web0, input logic [1:0] wm,
                                input logic [5:0] a0, input logic [47:0] d0,
                                input logic csb1, input logic [5:0] a1,
                                input logic [47:0] e0, input logic [47:0] e1);
        vec_t v;
        v.csb0 = csb0; v.web0 = web0; v.wmask0 = wm; v.addr0 = a0; v.din0 = d0;
        v.csb1 = csb1; v.addr1 = a1; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic drive_idle();
        bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.wmask0 = '0; bus.addr0 = '0; bus.din0 = '0;
        bus.csb1 = 1'b1; bus.addr1 = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk0);
        bus.csb0 = v.csb0; bus.web0 = v.web0; bus.wmask0 = v.wmask0;
        bus.addr0 = v.addr0; bus.din0 = v.din0; bus.csb1 = v.csb1; bus.addr1 = v.addr1;
        @(posedge clk0);
        #1;
    endtask

    // Counts posedges after rst falls until init_done is seen high.
    task automatic wait_init(output int n);
        n = 0;
        while (bus.init_done !== 1'b1 && n < 200) begin
            @(posedge clk0);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        drive_idle();
        p_bus.csb0 = 1'b1; p_bus.web0 = 1'b1; p_bus.wmask0 = '0; p_bus.addr0 = '0; p_bus.din0 = '0;
        p_bus.csb1 = 1'b1; p_bus.addr1 = '0;
        rst   = 1'b1;
        rst_p = 1'b1;

        // Clear sequence: two reset cycles then exactly 64 clear cycles.
        repeat (2) @(posedge clk0);
        #1;
        check("reset_init_done", {63'd0, bus.init_done}, 64'd0);
        check("reset_dout0", {16'd0, bus.dout0}, 64'd0);
        check("reset_dout1", {16'd0, bus.dout1}, 64'd0);
        @(negedge clk0);
        rst = 1'b0;
        wait_init(n);
        check("clear_cycles", 64'(n), 64'd64);

        for (int a = 0; a < 64; a++) begin
            apply(mk(1'b0, 1'b1, 2'b00, 6'(a), 48'h0, 1'b0, 6'(63 - a), 48'h0, 48'h0));
            check($sformatf("cleared_p0_%0d", a), {16'd0, bus.dout0}, 64'd0);
            check($sformatf("cleared_p1_%0d", 63 - a), {16'd0, bus.dout1}, 64'd0);
        end

        vecs.push_back(mk(0, 0, 2'b01, 6'd5, 48'hAAAAAA_BBBBBB, 1, 6'd0, 48'h0, 48'h0));
        vecs.push_back(mk(0, 0, 2'b10, 6'd5, 48'h123456_FFFFFF, 1, 6'd0, 48'h0, 48'h0));
        vecs.push_back(mk(0, 1, 2'b00, 6'd5, 48'h0, 1, 6'd0, 48'h123456_BBBBBB, 48'h0));
        vecs.push_back(mk(0, 0, 2'b11, 6'd9, 48'hCAFE00_00BEEF, 0, 6'd5, 48'h123456_BBBBBB, 48'h123456_BBBBBB));
        vecs.push_back(mk(0, 1, 2'b00, 6'd5, 48'h0, 0, 6'd9, 48'h123456_BBBBBB, 48'hCAFE00_00BEEF));
        vecs.push_back(mk(1, 1, 2'b00, 6'd0, 48'h0, 1, 6'd0, 48'h123456_BBBBBB, 48'hCAFE00_00BEEF));
        vecs.push_back(mk(1, 1, 2'b00, 6'd1, 48'h0, 1, 6'd2, 48'h123456_BBBBBB, 48'hCAFE00_00BEEF));
        vecs.push_back(mk(1, 0, 2'b11, 6'd5, 48'hFFFFFF_FFFFFF, 1, 6'd5, 48'h123456_BBBBBB, 48'hCAFE00_00BEEF));
        vecs.push_back(mk(0, 0, 2'b10, 6'd7, 48'h111111_222222, 0, 6'd7, 48'h123456_BBBBBB, COLL7));
        vecs.push_back(mk(0, 1, 2'b00, 6'd7, 48'h0, 0, 6'd7, 48'h111111_000000, 48'h111111_000000));
        vecs.push_back(mk(0, 0, 2'b00, 6'd5, 48'h0, 0, 6'd63, 48'h111111_000000, 48'h0));
        vecs.push_back(mk(0, 1, 2'b00, 6'd5, 48'h0, 0, 6'd9, 48'h123456_BBBBBB, 48'hCAFE00_00BEEF));
        vecs.push_back(mk(0, 0, 2'b01, 6'd9, 48'hFFFFFF_000000, 0, 6'd9, 48'h123456_BBBBBB, COLL9));
        vecs.push_back(mk(0, 1, 2'b00, 6'd9, 48'h0, 1, 6'd0, 48'hCAFE00_000000, COLL9));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_dout0", i), {16'd0, bus.dout0}, {16'd0, vecs[i].exp0});
            check($sformatf("vec%0d_dout1", i), {16'd0, bus.dout1}, {16'd0, vecs[i].exp1});
        end

        // Reset from READY, then reset again mid-clear at clear cycle 30.
        @(negedge clk0);
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk0);
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 20) begin
                bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 2'b11;
                bus.addr0 = 6'd10; bus.din0 = 48'hFFFFFF_FFFFFF;
                bus.csb1 = 1'b0; bus.addr1 = 6'd9;
            end
            @(posedge clk0);
            #1;
            if (c == 20) begin
                check("clear_write_dout0", {16'd0, bus.dout0}, 64'd0);
                check("clear_read_dout1", {16'd0, bus.dout1}, 64'd0);
            end
            @(negedge clk0);
            drive_idle();
        end
        check("midclear_init_done", {63'd0, bus.init_done}, 64'd0);
        rst = 1'b1;
        @(posedge clk0);
        #1;
        check("midclear_rst_init_done", {63'd0, bus.init_done}, 64'd0);
        @(negedge clk0);
        rst = 1'b0;
        wait_init(n);
        check("reclear_cycles", 64'(n), 64'd64);
        apply(mk(0, 1, 2'b00, 6'd10, 48'h0, 0, 6'd5, 48'h0, 48'h0));
        check("reclear_addr10", {16'd0, bus.dout0}, 64'd0);
        check("reclear_addr5", {16'd0, bus.dout1}, 64'd0);
        apply(mk(0, 1, 2'b00, 6'd9, 48'h0, 0, 6'd7, 48'h0, 48'h0));
        check("reclear_addr9", {16'd0, bus.dout0}, 64'd0);
        check("reclear_addr7", {16'd0, bus.dout1}, 64'd0);

        // 64-bit word, 16 entries, byte lanes.
        @(negedge clk0);
        rst_p = 1'b1;
        repeat (2) @(negedge clk0);
        rst_p = 1'b0;
        n = 0;
        while (p_bus.init_done !== 1'b1 && n < 100) begin
            @(posedge clk0);
            #1;
            n++;
        end
        check("p_clear_cycles", 64'(n), 64'd16);
        @(negedge clk0);
        p_bus.csb0 = 1'b0; p_bus.web0 = 1'b0; p_bus.wmask0 = 8'hFF;
        p_bus.addr0 = 4'd3; p_bus.din0 = 64'h0011_2233_4455_6677;
        @(negedge clk0);
        p_bus.wmask0 = 8'h81; p_bus.din0 = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk0);
        p_bus.web0 = 1'b1; p_bus.wmask0 = 8'h00; p_bus.addr0 = 4'd3;
        p_bus.csb1 = 1'b0; p_bus.addr1 = 4'd4;
        @(posedge clk0);
        #1;
        check("p_lane_dout0", p_bus.dout0, 64'hAA11_2233_4455_66AA);
        check("p_untouched_dout1", p_bus.dout1, 64'd0);
        @(negedge clk0);
        p_bus.csb0 = 1'b1; p_bus.addr1 = 4'd3;
        @(posedge clk0);
        #1;
        check("p_lane_dout1", p_bus.dout1, 64'hAA11_2233_4455_66AA);
        check("p_hold_dout0", p_bus.dout0, 64'hAA11_2233_4455_66AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
